// File: rtl/pc_pipe_pkg.sv
// Shared constants and payload type for the PC pipeline register stage.
package pc_pipe_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  cur_addr;
    logic [ADDR_W_DEF-1:0]  next_addr;
    logic [INSTR_W_DEF-1:0] instr;
  } pc_payload_t;

endpackage

// File: rtl/pc_pipe_reg_if.sv
// Upstream/downstream handshake bundle for pc_pipe_reg.
interface pc_pipe_reg_if
  import pc_pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_cur_addr;
  logic [ADDR_W-1:0]  in_next_addr;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_cur_addr;
  logic [ADDR_W-1:0]  out_next_addr;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         occupancy;

  modport master (
    output in_valid, in_cur_addr, in_next_addr, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_cur_addr, out_next_addr, out_instr, occupancy
  );

  modport slave (
    input  in_valid, in_cur_addr, in_next_addr, in_instr, flush, out_ready,
    output in_ready, out_valid, out_cur_addr, out_next_addr, out_instr, occupancy
  );

endinterface

// File: rtl/pc_pipe_slot.sv
// One buffer slot: valid bit plus payload register; clear wins over load.
module pc_pipe_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clear drops only the valid bit; payload bits keep their old value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pc_pipe_reg.sv
// Two-entry skid-buffered pipeline register carrying PC/next-PC/instruction.
module pc_pipe_reg
  import pc_pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input logic          clk,
  input logic          reset,
  pc_pipe_reg_if.slave bus
);

  localparam int PW = 2 * ADDR_W + INSTR_W;

  logic          main_v, skid_v;
  logic [PW-1:0] main_data, skid_data, in_data, main_src;
  logic          accept, consume;
  logic          main_load, main_clear, skid_load, skid_clear;

  assign in_data = {bus.in_cur_addr, bus.in_next_addr, bus.in_instr};

  assign accept  = bus.in_valid & ~skid_v;
  assign consume = main_v & bus.out_ready;

  // An accept implies the skid is empty, so the skid never competes with in_data.
  assign main_load  = ~bus.flush & ((accept & (~main_v | consume)) | (consume & skid_v));
  assign main_src   = skid_v ? skid_data : in_data;
  assign main_clear = bus.flush | (consume & ~main_load);

  assign skid_load  = ~bus.flush & accept & main_v & ~consume;
  assign skid_clear = bus.flush | (consume & skid_v);

  pc_pipe_slot #(.W(PW)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_src),
    .valid_o (main_v),
    .data_o  (main_data)
  );

  pc_pipe_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (in_data),
    .valid_o (skid_v),
    .data_o  (skid_data)
  );

  assign bus.in_ready  = ~skid_v;
  assign bus.out_valid = main_v;
  assign {bus.out_cur_addr, bus.out_next_addr, bus.out_instr} = main_data;
  assign bus.occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pc_pipe_reg.sv
// Bench for pc_pipe_reg: directed scenarios plus random traffic against a queue model.
module tb_pc_pipe_reg;
  import pc_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_pipe_reg_if nbus ();
  pc_pipe_reg_if #(.ADDR_W(32), .INSTR_W(32)) wbus ();

  pc_pipe_reg dut_n (.clk(clk), .reset(reset), .bus(nbus.slave));
  pc_pipe_reg #(.ADDR_W(32), .INSTR_W(32)) dut_w (.clk(clk), .reset(reset), .bus(wbus.slave));

  pc_payload_t q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    check("out_valid", 64'(nbus.out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(nbus.in_ready), 64'(q.size() < 2));
    check("occupancy", 64'(nbus.occupancy), 64'(q.size()));
    if (q.size() > 0) begin
      check("out_cur_addr", 64'(nbus.out_cur_addr), 64'(q[0].cur_addr));
      check("out_next_addr", 64'(nbus.out_next_addr), 64'(q[0].next_addr));
      check("out_instr", 64'(nbus.out_instr), 64'(q[0].instr));
    end
  endtask

  // Model: a FIFO of depth 2; consume pops the head, accept appends, flush/reset empty it.
  task automatic tick(output bit acc);
    bit          con, rst_now, fl_now;
    pc_payload_t p;
    acc     = nbus.in_valid && (q.size() < 2);
    con     = (q.size() > 0) && nbus.out_ready;
    rst_now = reset;
    fl_now  = nbus.flush;
    p = '{cur_addr: nbus.in_cur_addr, next_addr: nbus.in_next_addr, instr: nbus.in_instr};
    @(posedge clk);
    #1;
    if (rst_now || fl_now) begin
      q.delete();
      acc = 1'b0;
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(p);
    end
    compare_model();
    if (rst_now) begin
      check("rst_cur_addr", 64'(nbus.out_cur_addr), 64'h0);
      check("rst_next_addr", 64'(nbus.out_next_addr), 64'h0);
      check("rst_instr", 64'(nbus.out_instr), 64'h0);
    end
  endtask

  task automatic offer(input bit v, input logic [7:0] c);
    nbus.in_valid     = v;
    nbus.in_cur_addr  = c;
    nbus.in_next_addr = c + 8'd1;
    nbus.in_instr     = {c, ~c};
  endtask

  initial begin
    bit acc;
    reset          = 1'b1;
    nbus.flush     = 1'b0;
    nbus.out_ready = 1'b0;
    offer(1'b1, 8'h55);
    wbus.in_valid     = 1'b0;
    wbus.in_cur_addr  = '0;
    wbus.in_next_addr = '0;
    wbus.in_instr     = '0;
    wbus.flush        = 1'b0;
    wbus.out_ready    = 1'b0;

    // Reset held two cycles with a payload offered.
    tick(acc);
    tick(acc);
    reset = 1'b0;

    // Streaming.
    nbus.out_ready = 1'b1;
    for (int a = 8'h10; a <= 8'h12; a++) begin
      offer(1'b1, 8'(a));
      tick(acc);
      check("stream_head", 64'(nbus.out_cur_addr), 64'(a));
      check("stream_occ", 64'(nbus.occupancy), 64'd1);
    end
    offer(1'b0, 8'h00);
    tick(acc);

    // Backpressure: fill both slots, third offer stalls until drain.
    nbus.out_ready = 1'b0;
    offer(1'b1, 8'h20);
    tick(acc);
    offer(1'b1, 8'h21);
    tick(acc);
    check("bp_occ2", 64'(nbus.occupancy), 64'd2);
    check("bp_ready0", 64'(nbus.in_ready), 64'd0);
    offer(1'b1, 8'h22);
    tick(acc);
    check("bp_third_rejected", 64'(acc), 64'd0);
    check("bp_head_stable", 64'(nbus.out_cur_addr), 64'h20);
    nbus.out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 4 && !acc; k++) tick(acc);
    check("bp_third_accepted", 64'(acc), 64'd1);
    offer(1'b0, 8'h00);
    tick(acc);
    check("bp_last_out", 64'(nbus.out_cur_addr), 64'h22);
    tick(acc);

    // Flush with a full buffer and a simultaneous offer.
    nbus.out_ready = 1'b0;
    offer(1'b1, 8'h01);
    tick(acc);
    offer(1'b1, 8'h02);
    tick(acc);
    nbus.flush = 1'b1;
    offer(1'b1, 8'h30);
    tick(acc);
    check("flush_valid", 64'(nbus.out_valid), 64'd0);
    check("flush_occ", 64'(nbus.occupancy), 64'd0);
    nbus.flush     = 1'b0;
    nbus.out_ready = 1'b1;
    offer(1'b0, 8'h00);
    tick(acc);
    tick(acc);

    // Reset while the skid slot is occupied.
    nbus.out_ready = 1'b0;
    offer(1'b1, 8'h03);
    tick(acc);
    offer(1'b1, 8'h04);
    tick(acc);
    reset = 1'b1;
    offer(1'b0, 8'h00);
    tick(acc);
    reset          = 1'b0;
    nbus.out_ready = 1'b1;
    offer(1'b1, 8'h40);
    tick(acc);
    check("post_reset_first", 64'(nbus.out_cur_addr), 64'h40);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(63) == 0);
      nbus.flush     = ($urandom_range(15) == 0);
      nbus.out_ready = $urandom_range(1);
      nbus.in_valid     = $urandom_range(1);
      nbus.in_cur_addr  = 8'($urandom);
      nbus.in_next_addr = 8'($urandom);
      nbus.in_instr     = 16'($urandom);
      tick(acc);
    end
    reset      = 1'b0;
    nbus.flush = 1'b0;
    offer(1'b0, 8'h00);

    // Wide instance: full-width fields pass through unmodified.
    wbus.in_valid     = 1'b1;
    wbus.in_cur_addr  = 32'h1234_5678;
    wbus.in_next_addr = 32'hFFFF_FFFC;
    wbus.in_instr     = 32'hDEAD_BEEF;
    wbus.out_ready    = 1'b1;
    @(posedge clk);
    #1;
    wbus.in_valid = 1'b0;
    check("wide_valid", 64'(wbus.out_valid), 64'd1);
    check("wide_cur", 64'(wbus.out_cur_addr), 64'h1234_5678);
    check("wide_next", 64'(wbus.out_next_addr), 64'hFFFF_FFFC);
    check("wide_instr", 64'(wbus.out_instr), 64'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_pipe_reg.md
PC_PIPE_REG -- requirements
Module: pc_pipe_reg

Interface
REQ-001 Parameter ADDR_W, default 8, width of both address fields.
REQ-002 Parameter INSTR_W, default 16, width of the instruction word field.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream offers a payload this cycle.
REQ-007 in_ready  output  1  stage can accept a payload; registered, no combinational path from out_ready.
REQ-008 in_cur_addr  input  ADDR_W  current address of the offered payload.
REQ-009 in_next_addr  input  ADDR_W  next instruction address of the offered payload.
REQ-010 in_instr  input  INSTR_W  instruction word of the offered payload.
REQ-011 flush  input  1  discard all held payloads (branch or exception redirect).
REQ-012 out_valid  output  1  out_* fields hold a valid payload.
REQ-013 out_ready  input  1  downstream consumes the payload when out_valid is high.
REQ-014 out_cur_addr / out_next_addr / out_instr  output  ADDR_W / ADDR_W / INSTR_W  head payload.
REQ-015 occupancy  output  2  number of payloads held, 0 to 2.

Function
REQ-016 The block SHALL hold a two-entry buffer: a main slot driving out_*, and a skid slot.
REQ-017 An accept SHALL occur when in_valid and in_ready are both high; a consume SHALL occur when out_valid and out_ready are both high.
REQ-018 On an accept, the payload SHALL go to the main slot if the main slot is empty or being consumed that cycle and the skid slot is empty; otherwise it SHALL go to the skid slot.
REQ-019 On a consume with the skid slot full, the skid payload SHALL move to the main slot in the same edge, preserving order.
REQ-020 Latency SHALL be one cycle: a payload accepted at edge N appears on out_* with out_valid high after edge N when the buffer was empty.
REQ-021 in_ready SHALL be high exactly when the skid slot is empty after the current edge.
REQ-022 A simultaneous accept and consume with occupancy 1 SHALL leave occupancy 1 and load the new payload into the main slot.
REQ-023 A simultaneous accept and consume with occupancy 2 SHALL NOT occur, because in_ready is low at occupancy 2.
REQ-024 With occupancy 2 and out_ready low, all state SHALL hold and out_* SHALL remain stable.
REQ-025 flush SHALL take priority over accept and consume: the next edge clears both slots, occupancy goes to 0, out_valid goes to 0 and in_ready goes to 1.
REQ-026 A payload offered in the flush cycle SHALL be discarded.
REQ-027 Slot data SHALL be loaded only on accept or skid-to-main transfer; out_* data after a flush SHALL be unspecified, and only out_valid is meaningful.
REQ-028 occupancy SHALL equal the main-slot valid bit plus the skid-slot valid bit, registered.

Reset
REQ-029 The outputs SHALL take these values while reset is high at an edge:
- out_valid = 0
- occupancy = 0
- in_ready = 1
- out_cur_addr, out_next_addr and out_instr all zero
- skid slot cleared to zero
REQ-030 reset SHALL take priority over flush, in_valid and out_ready, and SHALL be effective mid-transfer with no payload surviving.

Structure
REQ-031 A shared package pc_pipe_pkg SHALL hold the default ADDR_W and INSTR_W constants and a payload typedef (cur_addr, next_addr, instr).
REQ-032 Each slot SHALL be an instance of the sub-module pc_pipe_slot, which has a valid bit, a payload register, load/clear inputs and synchronous reset; pc_pipe_reg instantiates it twice.

Verification
REQ-033 Reset-out: assert reset for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_cur_addr=0x00.
REQ-034 Streaming: out_ready=1, feed cur_addr 0x10,0x11,0x12 on consecutive cycles -> they appear one cycle later in order, occupancy stays 1 and in_ready stays 1.
REQ-035 Backpressure: out_ready=0, offer 0x20 then 0x21 -> occupancy=2 and in_ready=0 after the second edge; a third offer of 0x22 is not accepted; raise out_ready -> 0x20, 0x21 then 0x22 emerge in order with no loss or duplication.
REQ-036 Flush-full: occupancy=2, assert flush together with in_valid carrying 0x30 -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x30 never appears.
REQ-037 Reset mid-skid: occupancy=2, assert reset one cycle -> out_valid=0, out_cur_addr=0x00, occupancy=0; the first post-reset payload 0x40 is the first one out.
REQ-038 Width: ADDR_W=32, INSTR_W=32, feed next_addr 0xFFFFFFFC and instr 0xDEADBEEF -> both appear unmodified at the outputs.
